// File: rtl/card_shoe.sv
// Single-deck shoe dealing without replacement: an LFSR picks a start slot and a
// used-card bitmap with linear probing guarantees every card is unique until a reshuffle.
module card_shoe #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned RESHUFFLE_AT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_req,
    input  logic       shuffle_req,
    output logic       card_valid,
    output logic [3:0] card_value,
    output logic [5:0] card_index,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       reshuffled
);

    // state | meaning
    // IDLE  | waiting for draw_req; applies manual, pending or automatic reshuffles
    // PICK  | turn the current LFSR value into the first probe slot
    // PROBE | walk forward (with wrap) until a free slot is found and claimed
    // DONE  | present card_valid for one cycle
    typedef enum logic [1:0] {IDLE, PICK, PROBE, DONE} state_t;

    localparam logic [5:0] DECK       = 6'd52;
    localparam logic [5:0] RESHUF_LVL = 6'(RESHUFFLE_AT);

    state_t      state_q, state_d;
    logic [51:0] used_q, used_d;
    logic [5:0]  left_q, left_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  val_q, val_d;
    logic        pend_q, pend_d;
    logic [15:0] lfsr_q;
    logic        clear;
    logic [5:0]  pick_c;
    logic [5:0]  rank;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            used_q  <= '0;
            left_q  <= DECK;
            ptr_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            pend_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            left_q  <= left_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            pend_q  <= pend_d;
            // x^16 + x^14 + x^13 + x^11, free-running in every state
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_comb begin
        state_d = state_q;
        used_d  = used_q;
        left_d  = left_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        val_d   = val_q;
        pend_d  = pend_q;
        clear   = 1'b0;
        pick_c  = lfsr_q[5:0];
        rank    = ptr_q % 6'd13;

        if (state_q != IDLE && shuffle_req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (shuffle_req || pend_q || (draw_req && left_q <= RESHUF_LVL)) begin
                    clear = 1'b1;
                end
                if (draw_req) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                ptr_d   = (pick_c >= DECK) ? pick_c - DECK : pick_c;
                state_d = PROBE;
            end
            PROBE: begin
                if (used_q[ptr_q]) begin
                    ptr_d = (ptr_q == 6'd51) ? 6'd0 : ptr_q + 6'd1;
                end else begin
                    used_d[ptr_q] = 1'b1;
                    left_d        = left_q - 6'd1;
                    idx_d         = ptr_q;
                    val_d         = (rank >= 6'd9) ? 4'd10 : 4'(rank + 6'd1);
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The clear lands before a same-cycle draw, so that draw sees a full deck.
        if (clear) begin
            used_d = '0;
            left_d = DECK;
            pend_d = 1'b0;
        end
    end

    assign card_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign card_value = val_q;
    assign card_index = idx_q;
    assign cards_left = left_q;
    assign reshuffled = clear & ~reset;

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a transaction-level shoe model predicts every cycle's outputs,
// plus directed scenarios with hand-derived expectations.
module tb_card_shoe;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          RA   = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       draw_req = 1'b0;
    logic       shuffle_req = 1'b0;
    logic       card_valid;
    logic [3:0] card_value;
    logic [5:0] card_index;
    logic       busy;
    logic [5:0] cards_left;
    logic       reshuffled;

    card_shoe #(.LFSR_SEED(SEED), .RESHUFFLE_AT(RA)) dut (
        .clk(clk), .reset(reset), .draw_req(draw_req), .shuffle_req(shuffle_req),
        .card_valid(card_valid), .card_value(card_value), .card_index(card_index),
        .busy(busy), .cards_left(cards_left), .reshuffled(reshuffled)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Shoe model: a draw is resolved completely when accepted; visible results commit at DONE.
    int          cyc = 0;
    bit          used_m[52];
    int          left_m = 52, idx_m = 0, val_m = 0;
    int          st_m = 1, done_m = 0;
    int          p_left = 0, p_idx = 0, p_val = 0;
    bit          pend_m = 1'b0;
    logic [15:0] lfsr_m = SEED;

    always @(posedge clk) begin
        int cur, s, k, slot;
        logic [15:0] pk;
        cur = cyc;
        if (reset) begin
            foreach (used_m[i]) used_m[i] = 1'b0;
            left_m = 52; idx_m = 0; val_m = 0; pend_m = 1'b0;
            st_m = 1; done_m = 0;
            lfsr_m = SEED;
        end else begin
            if (cur >= st_m && cur <= done_m) begin
                if (shuffle_req) pend_m = 1'b1;
            end else begin
                if (shuffle_req || pend_m || (draw_req && left_m <= RA)) begin
                    foreach (used_m[i]) used_m[i] = 1'b0;
                    left_m = 52;
                    pend_m = 1'b0;
                end
                if (draw_req) begin
                    pk = lstep(lfsr_m);
                    s = int'(pk[5:0]);
                    if (s >= 52) s -= 52;
                    k = 0;
                    while (k < 52 && used_m[(s + k) % 52]) k++;
                    slot = (s + k) % 52;
                    used_m[slot] = 1'b1;
                    st_m   = cur + 1;
                    done_m = cur + 3 + k;
                    p_idx  = slot;
                    p_val  = (slot % 13 + 1 > 10) ? 10 : slot % 13 + 1;
                    p_left = left_m - 1;
                end
            end
            lfsr_m = lstep(lfsr_m);
        end
        cyc = cur + 1;
        if (cyc == done_m) begin
            left_m = p_left; idx_m = p_idx; val_m = p_val;
        end
    end

    int vcnt = 0, last_v = -1, last_r = -1;
    int hist[16];
    bit seen[64];
    int seqv[$];

    always @(negedge clk) begin
        bit bsy;
        if (!reset) begin
            bsy = (cyc >= st_m && cyc <= done_m);
            chk("busy", busy, bsy);
            chk("card_valid", card_valid, cyc == done_m);
            chk("cards_left", cards_left, left_m);
            chk("card_index", card_index, idx_m);
            chk("card_value", card_value, val_m);
            chk("reshuffled", reshuffled,
                !bsy && (shuffle_req || pend_m || (draw_req && left_m <= RA)));
            if (card_valid) begin
                vcnt++;
                last_v = cyc;
                hist[card_value]++;
                seen[card_index] = 1'b1;
                seqv.push_back(int'(card_index));
            end
            if (reshuffled) last_r = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic draw(input bit shuf);
        draw_req = 1'b1;
        shuffle_req = shuf;
        tick(1);
        draw_req = 1'b0;
        shuffle_req = 1'b0;
    endtask

    task automatic run_seq(output int res[6]);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        seqv.delete();
        for (int i = 0; i < 6; i++) begin
            draw(1'b0);
            tick(59);
        end
        for (int i = 0; i < 6; i++) res[i] = (i < seqv.size()) ? seqv[i] : -1;
    endtask

    initial begin
        int t0, v0, l0, nd;
        int ra[6], rb[6];

        tick(3);
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_left", cards_left, 52);
        chk("reset_value", card_value, 0);
        chk("reset_index", card_index, 0);
        tick(2);

        // full deck
        foreach (hist[i]) hist[i] = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        v0 = vcnt;
        for (int i = 0; i < 52; i++) begin
            draw(1'b0);
            tick(59);
            chk("t1_left", cards_left, 51 - i);
        end
        chk("t1_valids", vcnt - v0, 52);
        nd = 0;
        foreach (seen[i]) if (seen[i]) nd++;
        chk("t1_distinct", nd, 52);
        for (int v = 1; v <= 9; v++) chk("t1_hist", hist[v], 4);
        chk("t1_hist10", hist[10], 16);

        // empty shoe auto-reshuffles on the draw
        t0 = cyc;
        draw(1'b0);
        tick(59);
        chk("t2_reshuf_cycle", last_r, t0);
        chk("t2_latency", last_v - t0, 3);
        chk("t2_left", cards_left, 51);

        // draw held through the busy window yields one card
        v0 = vcnt;
        l0 = int'(cards_left);
        draw_req = 1'b1;
        tick(3);
        draw_req = 1'b0;
        tick(60);
        chk("t3_valids", vcnt - v0, 1);
        chk("t3_left", cards_left, l0 - 1);

        // shuffle during a draw is deferred until after delivery
        v0 = vcnt;
        draw(1'b0);
        shuffle_req = 1'b1;
        tick(1);
        shuffle_req = 1'b0;
        tick(60);
        chk("t4_valids", vcnt - v0, 1);
        chk("t4_reshuf_after_done", last_r - last_v, 1);
        chk("t4_left", cards_left, 52);

        // draw + shuffle in the same cycle at cards_left=10
        for (int i = 0; i < 42; i++) begin
            draw(1'b0);
            tick(59);
        end
        chk("t5_left_pre", cards_left, 10);
        t0 = cyc;
        draw(1'b1);
        tick(59);
        chk("t5_reshuf_cycle", last_r, t0);
        chk("t5_left", cards_left, 51);

        // reset in PROBE aborts the draw
        v0 = vcnt;
        draw(1'b0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_left", cards_left, 52);
        chk("t6_value", card_value, 0);
        tick(60);
        chk("t6_no_valid", vcnt - v0, 0);

        // same seed and timing give the same cards
        run_seq(ra);
        run_seq(rb);
        for (int i = 0; i < 6; i++) begin
            chk("t6_repeat", rb[i], ra[i]);
            chk("t6_recorded", ra[i] >= 0 && ra[i] < 52, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
